dut_prod_accum: RTL and testbench

DUT_PROD_ACCUM -- requirements
Module: dut_prod_accum

---
 rtl/dut_prod_accum.sv | 123 ++++++++++++
 tb/tb_dut_prod_accum.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dut_prod_accum.sv
// rtl/dut_prod_accum.sv - frame-based product accumulator with a registered sum output
// Optional saturation is enabled with `define DUT_PROD_ACCUM_SAT_EN; the default build wraps.
module dut_prod_accum #(
  parameter int PROD_W = 26,
  parameter int ACC_W  = 34,
  parameter int LEN_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] prod_din,
  input  logic              prod_vld,
  output logic              prod_rdy,
  input  logic [LEN_W-1:0]  frame_len,
  output logic [ACC_W-1:0]  sum_dout,
  output logic              sum_vld,
  input  logic              sum_rdy,
  output logic              sum_ovf,
  output logic              busy
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [LEN_W:0]     r_cnt;
  logic [LEN_W:0]     r_target;
  logic [ACC_W-1:0]   r_sum_dout;
  logic               r_sum_vld;

  logic               w_prod_xfer;
  logic               w_sum_xfer;
  logic [LEN_W:0]     w_len_ext;
  logic [LEN_W:0]     w_cnt_next;
  logic               w_done;
  logic [ACC_W-1:0]   w_add_a;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_acc_next;

  assign prod_rdy    = !r_sum_vld || sum_rdy;
  assign w_prod_xfer = prod_vld && prod_rdy;
  assign w_sum_xfer  = r_sum_vld && sum_rdy;

  // A zero frame length encodes the full 2^LEN_W products.
  assign w_len_ext  = (frame_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, frame_len};
  assign w_cnt_next = (r_state == S_IDLE) ? {{LEN_W{1'b0}}, 1'b1} : r_cnt + 1'b1;
  assign w_done     = w_prod_xfer &&
                      ((r_state == S_IDLE) ? (w_len_ext == {{LEN_W{1'b0}}, 1'b1})
                                           : (w_cnt_next == r_target));

  assign w_add_a    = (r_state == S_IDLE) ? '0 : r_acc;
  assign w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod_din};

`ifdef DUT_PROD_ACCUM_SAT_EN
  logic               r_ovf;
  logic               r_sum_ovf;
  logic [ACC_W:0]     w_sum_wide;
  logic               w_ovf_next;

  assign w_sum_wide = {1'b0, w_add_a} + {1'b0, w_prod_ext};
  assign w_acc_next = w_sum_wide[ACC_W] ? '1 : w_sum_wide[ACC_W-1:0];
  assign w_ovf_next = ((r_state == S_IDLE) ? 1'b0 : r_ovf) | w_sum_wide[ACC_W];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_ovf     <= 1'b0;
      r_sum_ovf <= 1'b0;
    end else begin
      if (w_prod_xfer) r_ovf <= w_ovf_next;
      if (w_done)      r_sum_ovf <= w_ovf_next;
      else if (w_sum_xfer) r_sum_ovf <= r_sum_ovf;
    end
  end

  assign sum_ovf = r_sum_ovf;
`else
  assign w_acc_next = w_add_a + w_prod_ext;
  assign sum_ovf    = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_prod_xfer) w_state_next = w_done ? S_IDLE : S_ACCUM;
  end

  always_comb begin
    busy = (r_state == S_ACCUM);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_target <= '0;
    end else if (w_prod_xfer) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      if (r_state == S_IDLE) r_target <= w_len_ext;
    end
  end

  // A completion on the same edge as a sum transfer reloads with no bubble.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_sum_dout <= '0;
      r_sum_vld  <= 1'b0;
    end else if (w_done) begin
      r_sum_dout <= w_acc_next;
      r_sum_vld  <= 1'b1;
    end else if (w_sum_xfer) begin
      r_sum_vld  <= 1'b0;
    end
  end

  assign sum_dout = r_sum_dout;
  assign sum_vld  = r_sum_vld;

endmodule

// File: tb/tb_dut_prod_accum.sv
// tb/tb_dut_prod_accum.sv - directed self-checking bench for dut_prod_accum
module tb_dut_prod_accum;

  localparam int PROD_W = 26;
  localparam int ACC_W  = 34;
  localparam int LEN_W  = 16;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [PROD_W-1:0] prod_din = '0;
  logic              prod_vld = 1'b0;
  logic              prod_rdy;
  logic [LEN_W-1:0]  frame_len = '0;
  logic [ACC_W-1:0]  sum_dout;
  logic              sum_vld;
  logic              sum_rdy = 1'b1;
  logic              sum_ovf;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int busy_cycles;

  dut_prod_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_din(prod_din), .prod_vld(prod_vld), .prod_rdy(prod_rdy),
    .frame_len(frame_len),
    .sum_dout(sum_dout), .sum_vld(sum_vld), .sum_rdy(sum_rdy),
    .sum_ovf(sum_ovf), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one product at the falling edge, let it transfer, sample 1 unit after the edge.
  task automatic push(input logic [PROD_W-1:0] d);
    @(negedge ap_clk);
    prod_din = d;
    prod_vld = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge ap_clk);
    prod_vld = 1'b0;
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #1;
    chk("reset_sum_vld", 64'(sum_vld), 64'd0);
    chk("reset_sum_dout", 64'(sum_dout), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_prod_rdy", 64'(prod_rdy), 64'd1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Four-product frame, sum 10, busy for three cycles.
    frame_len = 16'd4;
    sum_rdy = 1'b1;
    busy_cycles = 0;
    for (int i = 1; i <= 4; i++) begin
      push(PROD_W'(i));
      if (busy) busy_cycles++;
      if (i < 4) chk("f4_no_early_sum", 64'(sum_vld), 64'd0);
    end
    chk("f4_sum_vld", 64'(sum_vld), 64'd1);
    chk("f4_sum_dout", 64'(sum_dout), 64'd10);
    chk("f4_sum_ovf", 64'(sum_ovf), 64'd0);
    chk("f4_busy_cycles", 64'(busy_cycles), 64'd3);
    idle_cycles(1);
    chk("f4_sum_consumed", 64'(sum_vld), 64'd0);

    // Single-product frames back to back.
    frame_len = 16'd1;
    for (int i = 0; i < 3; i++) begin
      push(26'h3FFFFFF);
      chk("f1_sum_vld", 64'(sum_vld), 64'd1);
      chk("f1_sum_dout", 64'(sum_dout), 64'h3FFFFFF);
      chk("f1_busy", 64'(busy), 64'd0);
    end
    idle_cycles(1);

    // Downstream stall holds the sum and blocks input.
    frame_len = 16'd2;
    sum_rdy = 1'b0;
    push(26'd3);
    push(26'd4);
    chk("stall_sum_dout", 64'(sum_dout), 64'd7);
    @(negedge ap_clk);
    prod_din = 26'd5;
    prod_vld = 1'b1;
    chk("stall_prod_rdy", 64'(prod_rdy), 64'd0);
    repeat (3) @(posedge ap_clk);
    #1;
    chk("stall_hold_dout", 64'(sum_dout), 64'd7);
    chk("stall_hold_vld", 64'(sum_vld), 64'd1);
    chk("stall_no_accept", 64'(busy), 64'd0);
    @(negedge ap_clk);
    sum_rdy = 1'b1;
    #1;
    chk("stall_release_rdy", 64'(prod_rdy), 64'd1);
    @(posedge ap_clk);
    #1;
    chk("stall_first_taken", 64'(busy), 64'd1);
    chk("stall_sum_drained", 64'(sum_vld), 64'd0);
    push(26'd6);
    chk("stall_second_sum", 64'(sum_dout), 64'd11);
    chk("stall_second_vld", 64'(sum_vld), 64'd1);
    idle_cycles(1);

    // Reset mid-frame discards the partial sum.
    frame_len = 16'd4;
    push(26'd1);
    push(26'd2);
    @(negedge ap_clk);
    prod_vld = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum_dout", 64'(sum_dout), 64'd0);
    chk("rst_sum_vld", 64'(sum_vld), 64'd0);
    chk("rst_sum_ovf", 64'(sum_ovf), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    frame_len = 16'd2;
    push(26'd5);
    push(26'd6);
    chk("post_rst_sum", 64'(sum_dout), 64'd11);
    chk("post_rst_vld", 64'(sum_vld), 64'd1);
    idle_cycles(1);

    // Gaps and a mid-frame frame_len change leave the open frame alone.
    frame_len = 16'd3;
    push(26'd7);
    idle_cycles(2);
    frame_len = 16'd1;
    push(26'd8);
    chk("gap_no_early_sum", 64'(sum_vld), 64'd0);
    chk("gap_busy", 64'(busy), 64'd1);
    idle_cycles(2);
    push(26'd9);
    chk("gap_sum_dout", 64'(sum_dout), 64'd24);
    chk("gap_sum_vld", 64'(sum_vld), 64'd1);
    idle_cycles(1);

    // Full 2^16-product frame at maximum product value.
    frame_len = 16'd0;
    @(negedge ap_clk);
    prod_din = 26'h3FFFFFF;
    prod_vld = 1'b1;
    repeat (65535) @(posedge ap_clk);
    #1;
    chk("big_busy", 64'(busy), 64'd1);
    chk("big_no_early_sum", 64'(sum_vld), 64'd0);
    @(posedge ap_clk);
    #1;
    chk("big_sum_vld", 64'(sum_vld), 64'd1);
`ifdef DUT_PROD_ACCUM_SAT_EN
    chk("big_sum_dout", 64'(sum_dout), 64'h3FFFFFFFF);
    chk("big_sum_ovf", 64'(sum_ovf), 64'd1);
`else
    chk("big_sum_dout", 64'(sum_dout), 64'h3FFFF0000);
    chk("big_sum_ovf", 64'(sum_ovf), 64'd0);
`endif
    chk("big_busy_done", 64'(busy), 64'd0);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
